mby_wm_pkt_mux: RTL

//  Parametrised N-port packet aggregator that feeds the white-model packet channel.

---
 rtl/mby_wm_pkt_mux_if.sv | 42 ++++
 rtl/mby_wm_pkt_mux.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mby_wm_pkt_mux_if.sv
// Bundle of the per-port beat inputs, the serialised output beat and the statistics
// of the white-model packet aggregator.
interface mby_wm_pkt_mux_if #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 64,
  parameter int LEN_W     = 14
);
  localparam int BEAT_B = DATA_W / 8;
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int NB_W   = (BEAT_B > 1) ? $clog2(BEAT_B) : 1;

  logic [NUM_PORTS-1:0]        in_valid;
  logic [NUM_PORTS-1:0]        in_sop;
  logic [NUM_PORTS-1:0]        in_eop;
  logic [NUM_PORTS*DATA_W-1:0] in_data;
  logic [NUM_PORTS*NB_W-1:0]   in_nbytes;
  logic [NUM_PORTS-1:0]        in_ready;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_sop;
  logic              out_eop;
  logic [NB_W-1:0]   out_nbytes;
  logic [PORT_W-1:0] out_port;
  logic [LEN_W-1:0]  out_len;
  logic              out_err;
  logic [31:0]       stat_pkt_cnt;
  logic [15:0]       stat_err_cnt;

  modport master (
    output in_valid, in_sop, in_eop, in_data, in_nbytes, out_ready,
    input  in_ready, out_valid, out_data, out_sop, out_eop, out_nbytes,
           out_port, out_len, out_err, stat_pkt_cnt, stat_err_cnt
  );

  modport slave (
    input  in_valid, in_sop, in_eop, in_data, in_nbytes, out_ready,
    output in_ready, out_valid, out_data, out_sop, out_eop, out_nbytes,
           out_port, out_len, out_err, stat_pkt_cnt, stat_err_cnt
  );
endinterface

// File: rtl/mby_wm_pkt_mux.sv
// N-port packet aggregator: round-robin whole-packet arbitration into one registered
// output stream tagged with source port, byte length and error flag.
module mby_wm_pkt_mux #(
  parameter int NUM_PORTS     = 4,
  parameter int DATA_W        = 64,
  parameter int MAX_PKT_BYTES = 16383,
  parameter int LEN_W         = 14
) (
  input logic             clk,
  input logic             rst,
  mby_wm_pkt_mux_if.slave bus
);
  localparam int BEAT_B = DATA_W / 8;
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int NB_W   = (BEAT_B > 1) ? $clog2(BEAT_B) : 1;
  localparam int LW1    = LEN_W + 1;

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  state_t            r_state;
  logic [PORT_W-1:0] r_grant, r_rr_ptr;
  logic [LEN_W-1:0]  r_acc;
  logic              r_err;
  logic              r_out_valid, r_out_sop, r_out_eop, r_out_err;
  logic [DATA_W-1:0] r_out_data;
  logic [NB_W-1:0]   r_out_nbytes;
  logic [PORT_W-1:0] r_out_port;
  logic [LEN_W-1:0]  r_out_len;
  logic [31:0]       r_pkt_cnt;
  logic [15:0]       r_err_cnt;

  logic                 w_out_free, w_sop_hit, w_drop_hit, w_act, w_take, w_drop, w_lock;
  logic [PORT_W-1:0]    w_sop_port, w_drop_port, w_cur, w_next_ptr;
  logic                 w_b_sop, w_b_eop, w_ovf, w_new_err;
  logic [DATA_W-1:0]    w_b_data;
  logic [NB_W-1:0]      w_b_nb;
  logic [LW1-1:0]       w_beat_bytes, w_sum;
  logic [LEN_W-1:0]     w_base, w_new_acc;
  logic [NUM_PORTS-1:0] w_in_ready;

  // Rotating sop search from rr_ptr; the lowest stray non-sop port is the drop candidate.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first so no latch is inferred.
    w_sop_hit   = 1'b0;
    w_sop_port  = '0;
    w_drop_hit  = 1'b0;
    w_drop_port = '0;
    idx         = 0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (bus.in_valid[idx] && bus.in_sop[idx]) begin
        w_sop_hit  = 1'b1;
        w_sop_port = PORT_W'(idx);
      end
    end
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (bus.in_valid[p] && !bus.in_sop[p]) begin
        w_drop_hit  = 1'b1;
        w_drop_port = PORT_W'(p);
      end
    end
  end

  assign w_lock     = (r_state == S_LOCK);
  // Reset also forces in_ready low, not just the registers.
  assign w_out_free = !rst && (!r_out_valid || bus.out_ready);
  assign w_act      = w_lock || w_sop_hit;
  assign w_cur      = w_lock ? r_grant : w_sop_port;
  assign w_drop     = !w_lock && !w_sop_hit && w_drop_hit && w_out_free;

  assign w_b_data = bus.in_data[w_cur*DATA_W +: DATA_W];
  assign w_b_nb   = bus.in_nbytes[w_cur*NB_W +: NB_W];
  assign w_b_sop  = bus.in_sop[w_cur];
  assign w_b_eop  = bus.in_eop[w_cur];
  assign w_take   = w_act && w_out_free && bus.in_valid[w_cur];

  always_comb begin
    w_in_ready = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_in_ready[p] = (w_act && w_out_free && (w_cur == PORT_W'(p))) ||
                      (w_drop && (w_drop_port == PORT_W'(p)));
    end
  end

  // Length runs one bit wider than out_len so overflow is seen before saturating.
  assign w_beat_bytes = (w_b_eop && (w_b_nb != '0)) ? LW1'(w_b_nb) : LW1'(BEAT_B);
  assign w_base       = w_lock ? r_acc : '0;
  assign w_sum        = {1'b0, w_base} + w_beat_bytes;
  assign w_ovf        = (w_sum > LW1'(MAX_PKT_BYTES));
  assign w_new_acc    = w_ovf ? LEN_W'(MAX_PKT_BYTES) : w_sum[LEN_W-1:0];
  assign w_new_err    = (w_lock && (r_err || w_b_sop)) || w_ovf;
  assign w_next_ptr   = (w_cur == PORT_W'(NUM_PORTS - 1)) ? '0 : w_cur + PORT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_rr_ptr     <= '0;
      r_acc        <= '0;
      r_err        <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_sop    <= 1'b0;
      r_out_eop    <= 1'b0;
      r_out_err    <= 1'b0;
      r_out_data   <= '0;
      r_out_nbytes <= '0;
      r_out_port   <= '0;
      r_out_len    <= '0;
      r_pkt_cnt    <= '0;
      r_err_cnt    <= '0;
    end else begin
      if (w_take) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= w_b_data;
        r_out_sop    <= !w_lock;
        r_out_eop    <= w_b_eop;
        r_out_nbytes <= w_b_nb;
        r_out_port   <= w_cur;
        r_out_len    <= w_new_acc;
        r_out_err    <= w_new_err;
        if (w_b_eop) begin
          r_state  <= S_IDLE;
          r_rr_ptr <= w_next_ptr;
          r_acc    <= '0;
          r_err    <= 1'b0;
        end else begin
          r_state <= S_LOCK;
          r_grant <= w_cur;
          r_acc   <= w_new_acc;
          r_err   <= w_new_err;
        end
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (r_out_valid && bus.out_ready && r_out_eop && (r_pkt_cnt != '1))
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (((w_take && w_b_eop && w_new_err) || w_drop) && (r_err_cnt != '1))
        r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_data     = r_out_data;
  assign bus.out_sop      = r_out_sop;
  assign bus.out_eop      = r_out_eop;
  assign bus.out_nbytes   = r_out_nbytes;
  assign bus.out_port     = r_out_port;
  assign bus.out_len      = r_out_len;
  assign bus.out_err      = r_out_err;
  assign bus.stat_pkt_cnt = r_pkt_cnt;
  assign bus.stat_err_cnt = r_err_cnt;
endmodule
